// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile_if
//  Description : MEM/WB write-back inputs, ID-stage read ports and the
//                forwarding exports of the write-back register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       WB;
  logic [WIDTH-1:0] ReadData;
  logic [WIDTH-1:0] AluResult;
  logic [4:0]       WriteReg;
  logic [4:0]       ReadReg1;
  logic [4:0]       ReadReg2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [WIDTH-1:0] WriteData;
  logic             RegWrite_OUT;
  logic [4:0]       WriteReg_OUT;

  modport master (
    output WB, ReadData, AluResult, WriteReg, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteData, RegWrite_OUT, WriteReg_OUT
  );

  modport slave (
    input  WB, ReadData, AluResult, WriteReg, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteData, RegWrite_OUT, WriteReg_OUT
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : MIPS write-back stage plus 32-entry register file with
//                combinational reads and optional same-cycle write-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  wb_regfile_if.slave       bus
);

  // R0 is kept in the array but never written, so it stays at its reset value.
  logic [WIDTH-1:0] r_regs [32];
  logic [WIDTH-1:0] w_wdata;
  logic             w_we;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  // Write-back mux and effective write enable (writes to R0 are dropped).
  always_comb begin
    w_wdata = bus.WB[0] ? bus.ReadData : bus.AluResult;
    w_we    = bus.WB[1] && (bus.WriteReg != 5'd0);
  end

  // Register array commit; asynchronous clear of every entry.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[bus.WriteReg] <= w_wdata;
    end
  end

  // Read port 1: R0 reads zero, optional bypass of the in-flight write.
  always_comb begin
    w_rd1 = r_regs[bus.ReadReg1];
    if (bus.ReadReg1 == 5'd0) begin
      w_rd1 = '0;
    end else if (BYPASS && w_we && (bus.ReadReg1 == bus.WriteReg)) begin
      w_rd1 = w_wdata;
    end
  end

  // Read port 2: same selection as port 1, evaluated independently.
  always_comb begin
    w_rd2 = r_regs[bus.ReadReg2];
    if (bus.ReadReg2 == 5'd0) begin
      w_rd2 = '0;
    end else if (BYPASS && w_we && (bus.ReadReg2 == bus.WriteReg)) begin
      w_rd2 = w_wdata;
    end
  end

  // Output drive; data and enable are held at zero while reset is asserted,
  // the destination index always passes straight through.
  always_comb begin
    bus.ReadData1    = Rst_n ? w_rd1   : '0;
    bus.ReadData2    = Rst_n ? w_rd2   : '0;
    bus.WriteData    = Rst_n ? w_wdata : '0;
    bus.RegWrite_OUT = Rst_n & w_we;
    bus.WriteReg_OUT = bus.WriteReg;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Self-checking bench for wb_regfile; one instance with the
//                bypass enabled and one without, driven with identical inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        Clk;
  logic        Rst_n;
  logic [1:0]  tb_WB;
  logic [31:0] tb_ReadData;
  logic [31:0] tb_AluResult;
  logic [4:0]  tb_WriteReg;
  logic [4:0]  tb_ReadReg1;
  logic [4:0]  tb_ReadReg2;

  int total;
  int bad;

  exp_t        q_exp[$];
  logic [31:0] m_regs [32];

  wb_regfile_if #(.WIDTH(32)) bif1 ();
  wb_regfile_if #(.WIDTH(32)) bif0 ();

  assign bif1.WB        = tb_WB;
  assign bif1.ReadData  = tb_ReadData;
  assign bif1.AluResult = tb_AluResult;
  assign bif1.WriteReg  = tb_WriteReg;
  assign bif1.ReadReg1  = tb_ReadReg1;
  assign bif1.ReadReg2  = tb_ReadReg2;
  assign bif0.WB        = tb_WB;
  assign bif0.ReadData  = tb_ReadData;
  assign bif0.AluResult = tb_AluResult;
  assign bif0.WriteReg  = tb_WriteReg;
  assign bif0.ReadReg1  = tb_ReadReg1;
  assign bif0.ReadReg2  = tb_ReadReg2;

  wb_regfile #(.WIDTH(32), .BYPASS(1'b1)) u_dut_byp (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bif1.slave)
  );

  wb_regfile #(.WIDTH(32), .BYPASS(1'b0)) u_dut_nobyp (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bif0.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wdata();
    return tb_WB[0] ? tb_ReadData : tb_AluResult;
  endfunction

  function automatic logic m_we();
    return Rst_n && tb_WB[1] && (tb_WriteReg != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic byp);
    if (!Rst_n)                              return 32'h0;
    if (r == 5'd0)                           return 32'h0;
    if (byp && m_we() && (r == tb_WriteReg)) return m_wdata();
    return m_regs[r];
  endfunction

  // Push the model's expectations, let the DUTs settle, pop and compare.
  task automatic sample(input string name);
    exp_t e;
    e.tag = {name, ".b1.rd1"}; e.val = m_read(tb_ReadReg1, 1'b1);            q_exp.push_back(e);
    e.tag = {name, ".b1.rd2"}; e.val = m_read(tb_ReadReg2, 1'b1);            q_exp.push_back(e);
    e.tag = {name, ".wdata"};  e.val = Rst_n ? m_wdata() : 32'h0;            q_exp.push_back(e);
    e.tag = {name, ".we"};     e.val = {31'h0, m_we()};                      q_exp.push_back(e);
    e.tag = {name, ".wro"};    e.val = {27'h0, tb_WriteReg};                 q_exp.push_back(e);
    e.tag = {name, ".b0.rd1"}; e.val = m_read(tb_ReadReg1, 1'b0);            q_exp.push_back(e);
    e.tag = {name, ".b0.rd2"}; e.val = m_read(tb_ReadReg2, 1'b0);            q_exp.push_back(e);
    e.tag = {name, ".b0.we"};  e.val = {31'h0, m_we()};                      q_exp.push_back(e);
    #1;
    e = q_exp.pop_front(); chk(e.tag, bif1.ReadData1, e.val);
    e = q_exp.pop_front(); chk(e.tag, bif1.ReadData2, e.val);
    e = q_exp.pop_front(); chk(e.tag, bif1.WriteData, e.val);
    e = q_exp.pop_front(); chk(e.tag, {31'h0, bif1.RegWrite_OUT}, e.val);
    e = q_exp.pop_front(); chk(e.tag, {27'h0, bif1.WriteReg_OUT}, e.val);
    e = q_exp.pop_front(); chk(e.tag, bif0.ReadData1, e.val);
    e = q_exp.pop_front(); chk(e.tag, bif0.ReadData2, e.val);
    e = q_exp.pop_front(); chk(e.tag, {31'h0, bif0.RegWrite_OUT}, e.val);
  endtask

  // One rising edge; the model commits with the pre-edge inputs.
  task automatic tick();
    logic        we;
    logic [31:0] wd;
    we = m_we();
    wd = m_wdata();
    @(posedge Clk);
    if (Rst_n && we) m_regs[tb_WriteReg] = wd;
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
    tb_WB = wb; tb_AluResult = alu; tb_ReadData = ld;
    tb_WriteReg = wr; tb_ReadReg1 = r1; tb_ReadReg2 = r2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    // Reset held: writes suppressed, outputs forced to zero.
    Rst_n = 1'b0;
    drive(2'b10, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd5);
    #1;
    sample("rst0");
    repeat (3) tick();
    sample("rst3");

    // Release reset; a write to R0 is dropped.
    Rst_n = 1'b1;
    drive(2'b10, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 5'd5);
    sample("r0_pre");
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
    sample("r0_post");
    chk("r0_reads_zero", bif1.ReadData1, 32'h0);

    // ALU write-back into R3.
    drive(2'b10, 32'h00000011, 32'h22, 5'd3, 5'd3, 5'd0);
    sample("alu_pre");
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
    sample("alu_post");
    chk("alu_r3", bif0.ReadData1, 32'h00000011);

    // Load write-back into R31.
    drive(2'b11, 32'h99, 32'h12345678, 5'd31, 5'd0, 5'd31);
    sample("ld_pre");
    chk("ld_wdata", bif1.WriteData, 32'h12345678);
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd31, 5'd0, 5'd31);
    sample("ld_post");
    chk("ld_r31", bif0.ReadData2, 32'h12345678);

    // Same-cycle bypass on R7.
    drive(2'b10, 32'h1, 32'h0, 5'd7, 5'd0, 5'd0);
    tick();
    drive(2'b10, 32'h2, 32'h0, 5'd7, 5'd7, 5'd7);
    sample("byp_pre");
    chk("byp_on", bif1.ReadData1, 32'h2);
    chk("byp_off", bif0.ReadData2, 32'h1);
    drive(2'b00, 32'h2, 32'h0, 5'd7, 5'd7, 5'd7);
    sample("byp_nowb");
    chk("byp_nowb", bif1.ReadData2, 32'h1);
    drive(2'b01, 32'h2, 32'h0, 5'd7, 5'd7, 5'd7);
    sample("byp_m2r_only");
    drive(2'b10, 32'h2, 32'h0, 5'd7, 5'd7, 5'd7);
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    sample("byp_post");
    chk("byp_post", bif0.ReadData1, 32'h2);

    // Mid-cycle asynchronous reset clears R4 immediately.
    drive(2'b10, 32'hA5A5A5A5, 32'h0, 5'd4, 5'd4, 5'd31);
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd4, 5'd4, 5'd31);
    sample("r4_written");
    #2;
    Rst_n = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    sample("r4_in_rst");
    tick();
    Rst_n = 1'b1;
    sample("r4_after_rst");
    chk("r4_cleared", bif0.ReadData1, 32'h0);

    // Back-to-back writes to R9.
    for (int v = 1; v <= 3; v++) begin
      drive(2'b10, 32'(v), 32'h0, 5'd9, 5'd9, 5'd9);
      sample($sformatf("b2b_pre%0d", v));
      tick();
      drive(2'b00, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
      sample($sformatf("b2b_post%0d", v));
      chk($sformatf("b2b_val%0d", v), bif0.ReadData1, 32'(v));
    end

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      drive(2'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      sample($sformatf("rnd%0d", n));
      tick();
    end

    if (q_exp.size() != 0) begin
      chk("scoreboard_empty", 32'(q_exp.size()), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
